// File: rtl/gate_vector_sequencer.sv
// Stimulus/capture sequencer for the two-input basic-gate block: sweeps {a,b}, captures a 24-bit truth table.
// Optional golden compare (err_mask/pass) is compiled in with `define GVS_SELFCHECK_EN.
module gate_vector_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  input  logic        and_g,
  input  logic        or_g,
  input  logic        not_a_g,
  input  logic        xor_g,
  input  logic        xnor_g,
  input  logic        nand_g,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_mask,
  output logic [23:0] truth_table
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       sample;

  assign sample = {nand_g, xnor_g, xor_g, not_a_g, or_g, and_g};
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      cnt         <= '0;
      a           <= 1'b0;
      b           <= 1'b0;
      truth_table <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx         <= 2'd0;
            a           <= 1'b0;
            b           <= 1'b0;
            truth_table <= '0;
            cnt         <= SETTLE_LD;
            state       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_SAMPLE;
          else           cnt   <= cnt - CNT_ONE;
        end
        S_SAMPLE: begin
          truth_table[idx*6 +: 6] <= sample;
          if (idx == 2'd3) begin
            state <= S_DONE;
          end else begin
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
            cnt    <= SETTLE_LD;
            state  <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GVS_SELFCHECK_EN
  // Expected {nand,xnor,xor,not_a,or,and} word for each operand vector.
  function automatic logic [5:0] golden_word(input logic [1:0] i);
    case (i)
      2'd0:    golden_word = 6'h34;
      2'd1:    golden_word = 6'h2E;
      2'd2:    golden_word = 6'h2A;
      default: golden_word = 6'h13;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mask <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (start) err_mask <= '0;
        S_SAMPLE: err_mask <= err_mask | (sample ^ golden_word(idx));
        S_DONE:   pass <= (err_mask == '0);
        default:  ;
      endcase
    end
  end
`else
  assign err_mask = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pass <= 1'b0;
    else if (state == S_DONE) pass <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: SETTLE_CYCLES=1 and SETTLE_CYCLES=0 instances with a behavioural gate block.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start0, xor_fault;

  logic a1, b1, busy1, done1, pass1;
  logic [5:0]  err1, g1;
  logic [23:0] tt1;
  logic a0, b0, busy0, done0, pass0;
  logic [5:0]  err0, g0;
  logic [23:0] tt0;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural gate block; bit order {nand,xnor,xor,not_a,or,and}.
  function automatic logic [5:0] gate_model(input logic a, input logic b, input logic xf);
    logic x;
    x = xf ? 1'b0 : (a ^ b);
    gate_model = {~(a & b), ~(a ^ b), x, ~a, a | b, a & b};
  endfunction

  always_comb g1 = gate_model(a1, b1, xor_fault);
  always_comb g0 = gate_model(a0, b0, 1'b0);

  gate_vector_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .and_g(g1[0]), .or_g(g1[1]), .not_a_g(g1[2]), .xor_g(g1[3]), .xnor_g(g1[4]), .nand_g(g1[5]),
    .busy(busy1), .done(done1), .pass(pass1), .err_mask(err1), .truth_table(tt1)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .and_g(g0[0]), .or_g(g0[1]), .not_a_g(g0[2]), .xor_g(g0[3]), .xnor_g(g0[4]), .nand_g(g0[5]),
    .busy(busy0), .done(done0), .pass(pass0), .err_mask(err0), .truth_table(tt0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One sweep on the SETTLE_CYCLES=1 instance; edge 0 is the edge that accepts start.
  task automatic sweep1(input bit extra_pulses, output int done_edge, output int n_done,
                        output int seq_err, output logic busy_mid);
    done_edge = -1;
    n_done    = 0;
    seq_err   = 0;
    busy_mid  = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    if ({a1, b1} != 2'd0) seq_err++;
    for (int k = 1; k <= 20; k++) begin
      if (extra_pulses && (k == 3 || k == 7)) start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      if (k == 1) busy_mid = busy1;
      if (k < 12 && {a1, b1} != 2'(k / 3)) seq_err++;
      if (done1) begin
        n_done++;
        if (done_edge < 0) done_edge = k;
      end
    end
  endtask

  int de, nd, se;
  logic bm;
  int first_done, second_done, dones0;

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0; xor_fault = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_ab",   {a1, b1}, 2'b00);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_pass", pass1, 1'b0);
    check("rst_err",  err1, 6'h00);
    check("rst_tt",   tt1, 24'h0);

    // Healthy gate block
    sweep1(1'b0, de, nd, se, bm);
    check("ok_seq",       se, 0);
    check("ok_busy",      bm, 1'b1);
    check("ok_done_edge", de, 12);
    check("ok_done_cnt",  nd, 1);
    check("ok_tt",        tt1, 24'h4EABB4);
    check("ok_err",       err1, 6'h00);
    check("ok_pass",      pass1, 1'b1);
    check("ok_idle",      busy1, 1'b0);

    // xor output stuck at 0: vectors 01 and 10 read 0x26 and 0x22
    xor_fault = 1'b1;
    sweep1(1'b0, de, nd, se, bm);
    xor_fault = 1'b0;
    check("xf_tt", tt1, 24'h4E29B4);
`ifdef GVS_SELFCHECK_EN
    check("xf_err",  err1, 6'h08);
    check("xf_pass", pass1, 1'b0);
`else
    check("xf_err",  err1, 6'h00);
    check("xf_pass", pass1, 1'b1);
`endif

    // start pulses while busy are ignored
    sweep1(1'b1, de, nd, se, bm);
    check("busy_start_seq",  se, 0);
    check("busy_start_edge", de, 12);
    check("busy_start_cnt",  nd, 1);
    check("busy_start_pass", pass1, 1'b1);

    // Reset in the middle of vector idx2
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_ab_pre", {a1, b1}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ab",   {a1, b1}, 2'b00);
    check("mid_rst_tt",   tt1, 24'h0);
    check("mid_rst_busy", busy1, 1'b0);
    check("mid_rst_pass", pass1, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    sweep1(1'b0, de, nd, se, bm);
    check("post_rst_edge", de, 12);
    check("post_rst_tt",   tt1, 24'h4EABB4);
    check("post_rst_pass", pass1, 1'b1);

    // SETTLE_CYCLES=0, start held high across two sweeps
    first_done = -1; second_done = -1; dones0 = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (done0) begin
        dones0++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (k == 9) begin
        check("s0_idle_gap", busy0, 1'b0);
        check("s0_pass1",    pass0, 1'b1);
        check("s0_tt1",      tt0, 24'h4EABB4);
      end
      if (k == 18) start0 = 1'b0;
    end
    check("s0_first_done",  first_done, 8);
    check("s0_second_done", second_done, 18);
    check("s0_done_cnt",    dones0, 2);
    check("s0_pass2",       pass0, 1'b1);
    check("s0_tt2",         tt0, 24'h4EABB4);
    check("s0_err",         err0, 6'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
